// File: rtl/rom_bank_sched.sv
`default_nettype none
// ============================================================================
// Module      : rom_bank_sched
// Description : Word-aligned ROM bank scheduler for a 56-bit serial machine.
//               Tracks bit time from sync, captures the ROM address and
//               instruction, and drives the one-hot ROM enable of the bank.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_bank_sched (
    input  logic       cph2,
    input  logic       nrst,
    input  logic       sync,
    input  logic       ia,
    input  logic       is,
    output logic [7:0] rom_en,
    output logic [2:0] bank,
    output logic [7:0] addr,
    output logic       addr_vld,
    output logic       locked,
    output logic       sync_err,
    output logic       dly_pend
);

    localparam logic [5:0] C_T_LAST    = 6'd55;
    localparam logic [5:0] C_T_REALIGN = 6'd46;
    localparam logic [5:0] C_WIN_FIRST = 6'd45;
    localparam logic [5:0] C_WIN_LAST  = 6'd54;
    localparam logic [5:0] C_EN_FIRST  = 6'd44;
    localparam logic [5:0] C_ARM       = 6'd43;
    localparam logic [5:0] C_IA_FIRST  = 6'd20;
    localparam logic [5:0] C_IA_LAST   = 6'd27;
    localparam logic [6:0] C_OP_IMM    = 7'b0110000;
    localparam logic [6:0] C_OP_DLY    = 7'b1110000;
    localparam logic [6:0] C_OP_KEY    = 7'b0010000;

    logic [5:0] r_t;
    logic       r_sync_q;
    logic       r_armed;
    logic [6:0] r_ia_sr;
    logic [8:0] r_inst;
    logic [2:0] r_pend_tgt;

    logic       w_in_win;
    logic       w_rise;
    logic       w_mismatch;
    logic       w_active;
    logic       w_decode;
    logic [5:0] w_t_inc;
    logic [7:0] w_addr_full;
    logic [9:0] w_inst_full;

    assign w_in_win    = (r_t >= C_WIN_FIRST) && (r_t <= C_WIN_LAST);
    assign w_rise      = sync & ~r_sync_q;
    assign w_mismatch  = locked & (sync ^ w_in_win);
    assign w_active    = locked & ~w_mismatch;
    assign w_t_inc     = (r_t == C_T_LAST) ? 6'd0 : r_t + 6'd1;
    // The final serial bit is merged combinationally so the word completes on its last bit time.
    assign w_addr_full = {ia, r_ia_sr};
    assign w_inst_full = {is, r_inst};
    assign w_decode    = w_active && r_armed && (r_t == C_WIN_LAST);

    // r_armed marks a word that has been locked since before its enable window,
    // so a word joined mid-way never drives the bus nor decodes a partial instruction.
    always_ff @(posedge cph2) begin
        if (!nrst) begin
            r_t      <= 6'd0;
            r_sync_q <= 1'b0;
            r_armed  <= 1'b0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            r_sync_q <= sync;
            sync_err <= w_mismatch;
            if (w_mismatch) begin
                locked  <= 1'b0;
                r_armed <= 1'b0;
                r_t     <= w_t_inc;
            end else if (w_rise) begin
                locked  <= 1'b1;
                r_t     <= C_T_REALIGN;
            end else begin
                r_t <= w_t_inc;
                if (locked && (r_t == C_ARM)) begin
                    r_armed <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge cph2) begin
        if (!nrst) begin
            r_ia_sr  <= '0;
            r_inst   <= '0;
            addr     <= '0;
            addr_vld <= 1'b0;
        end else begin
            addr_vld <= 1'b0;
            if (w_active && (r_t >= C_IA_FIRST) && (r_t <= C_IA_LAST)) begin
                r_ia_sr <= w_addr_full[7:1];
                if (r_t == C_IA_LAST) begin
                    addr     <= w_addr_full;
                    addr_vld <= 1'b1;
                end
            end
            if (w_mismatch) begin
                r_inst <= '0;
            end else if (w_active && r_armed && w_in_win) begin
                r_inst <= w_inst_full[9:1];
            end
        end
    end

    always_ff @(posedge cph2) begin
        if (!nrst) begin
            bank       <= 3'd0;
            dly_pend   <= 1'b0;
            r_pend_tgt <= 3'd0;
        end else if (w_decode) begin
            if (w_inst_full[6:0] == C_OP_IMM) begin
                bank     <= w_inst_full[9:7];
                dly_pend <= 1'b0;
            end else if (w_inst_full[6:0] == C_OP_DLY) begin
                r_pend_tgt <= w_inst_full[9:7];
                dly_pend   <= 1'b1;
            end else if (w_inst_full[6:0] == C_OP_KEY) begin
                bank     <= 3'd0;
                dly_pend <= 1'b0;
            end else if (w_inst_full[0] && dly_pend) begin
                bank     <= r_pend_tgt;
                dly_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        rom_en = 8'h00;
        if (locked && r_armed && (r_t >= C_EN_FIRST) && (r_t <= C_WIN_LAST)) begin
            rom_en[bank] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_bank_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_bank_sched
// Description : Scoreboard bench for rom_bank_sched; word-level reference model
//               queues expected outcomes, a negedge monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_bank_sched;

    logic       cph2 = 1'b0;
    logic       nrst;
    logic       sync;
    logic       ia;
    logic       is;
    logic [7:0] rom_en;
    logic [2:0] bank;
    logic [7:0] addr;
    logic       addr_vld;
    logic       locked;
    logic       sync_err;
    logic       dly_pend;

    rom_bank_sched dut (
        .cph2     (cph2),
        .nrst     (nrst),
        .sync     (sync),
        .ia       (ia),
        .is       (is),
        .rom_en   (rom_en),
        .bank     (bank),
        .addr     (addr),
        .addr_vld (addr_vld),
        .locked   (locked),
        .sync_err (sync_err),
        .dly_pend (dly_pend)
    );

    always #5 cph2 = ~cph2;

    typedef struct {
        bit         rst;
        logic [7:0] en44;
        logic [7:0] en50;
        logic [2:0] bank;
        logic       dly;
        logic       lck;
        logic       err;
        logic [7:0] addr;
    } rec_t;

    rec_t       q_word[$];
    logic [7:0] q_addr[$];
    int n_chk = 0;
    int n_fail = 0;
    int bt = 0;
    int err_seen = 0;
    int err_exp = 0;
    int n_rst_pend = 0;
    bit rst_q = 1'b0;

    // Word-level reference model state
    bit         m_locked;
    logic [2:0] m_bank;
    logic [2:0] m_pend;
    bit         m_dly;
    logic [7:0] m_addr;

    always @(posedge cph2) rst_q <= !nrst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] onehot(input logic [2:0] b);
        logic [7:0] one;
        one = 8'h01;
        return one << b;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_bank   = 3'd0;
        m_pend   = 3'd0;
        m_dly    = 1'b0;
        m_addr   = 8'h00;
    endtask

    task automatic model_decode(input logic [9:0] inst);
        if (inst[6:0] == 7'b0110000) begin
            m_bank = inst[9:7];
            m_dly  = 1'b0;
        end else if (inst[6:0] == 7'b1110000) begin
            m_pend = inst[9:7];
            m_dly  = 1'b1;
        end else if (inst[6:0] == 7'b0010000) begin
            m_bank = 3'd0;
            m_dly  = 1'b0;
        end else if (inst[1:0] == 2'b11 || inst[1:0] == 2'b01) begin
            if (m_dly) begin
                m_bank = m_pend;
                m_dly  = 1'b0;
            end
        end
    endtask

    // kind: 0 immediate, 1 delayed, 2 key jump, 3 branch, 4 other
    function automatic logic [9:0] gen_inst(input int kind, input logic [2:0] tgt);
        logic [9:0] v;
        v = 10'($urandom);
        case (kind)
            0: v = {tgt, 7'b0110000};
            1: v = {tgt, 7'b1110000};
            2: v[6:0] = 7'b0010000;
            3: v[0] = 1'b1;
            default: v[1:0] = 2'b10;
        endcase
        return v;
    endfunction

    task automatic push_rst();
        rec_t z;
        z.rst = 1'b1; z.en44 = 8'h00; z.en50 = 8'h00; z.bank = 3'd0;
        z.dly = 1'b0; z.lck = 1'b0; z.err = 1'b0; z.addr = 8'h00;
        q_word.push_back(z);
        n_rst_pend++;
    endtask

    // One 56-bit word; the model fixes the word's outcome before it is driven.
    task automatic word(input bit drop, input logic [7:0] ia_b, input logic [9:0] inst, input bit do_rst);
        rec_t r;
        bit   wl;
        wl     = m_locked;
        r.rst  = 1'b0;
        r.en44 = wl ? onehot(m_bank) : 8'h00;
        r.en50 = r.en44;
        r.err  = 1'b0;
        if (wl) begin
            q_addr.push_back(ia_b);
            m_addr = ia_b;
        end
        if (!do_rst) begin
            if (drop) begin
                r.en50 = 8'h00;
                r.err  = wl;
                if (wl) err_exp++;
                m_locked = 1'b0;
            end else begin
                if (wl) model_decode(inst);
                m_locked = 1'b1;
            end
        end
        r.bank = m_bank; r.dly = m_dly; r.lck = m_locked; r.addr = m_addr;
        q_word.push_back(r);
        for (int p = 0; p < 56; p++) begin
            bt = p;
            if (do_rst && p == 50) begin
                push_rst();
                nrst = 1'b0;
                sync = 1'b0;
                model_reset();
                repeat (3) begin
                    @(posedge cph2);
                    #1;
                end
                nrst = 1'b1;
                break;
            end
            sync = !drop && (p >= 45) && (p <= 54);
            ia   = (p >= 20 && p <= 27) ? ia_b[p-20] : 1'($urandom);
            is   = (p >= 45 && p <= 54) ? inst[p-45] : 1'($urandom);
            @(posedge cph2);
            #1;
        end
    endtask

    rec_t       m_r;
    logic [7:0] m_a;
    always @(negedge cph2) begin
        if (rst_q) begin
            if (n_rst_pend > 0) begin
                while (q_word.size() > 0 && !q_word[0].rst) void'(q_word.pop_front());
                m_r = q_word.pop_front();
                n_rst_pend--;
                chk("rst_rom_en", rom_en, 8'h00);
                chk("rst_bank", bank, 3'd0);
                chk("rst_dly_pend", dly_pend, 1'b0);
                chk("rst_locked", locked, 1'b0);
                chk("rst_addr", addr, 8'h00);
                chk("rst_addr_vld", addr_vld, 1'b0);
                chk("rst_sync_err", sync_err, 1'b0);
            end
        end else begin
            if (addr_vld) begin
                chk("addr_vld_at_T28", bt, 28);
                if (q_addr.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL addr_unexpected: got %0h required no update", addr);
                end else begin
                    m_a = q_addr.pop_front();
                    chk("addr", addr, m_a);
                end
            end
            if (sync_err) err_seen++;
            if (q_word.size() > 0 && !q_word[0].rst) begin
                case (bt)
                    43: chk("rom_en_T43", rom_en, 8'h00);
                    44: chk("rom_en_T44", rom_en, q_word[0].en44);
                    46: chk("sync_err_T46", sync_err, q_word[0].err);
                    50: chk("rom_en_T50", rom_en, q_word[0].en50);
                    55: begin
                        m_r = q_word.pop_front();
                        chk("rom_en_T55", rom_en, 8'h00);
                        chk("bank_T55", bank, m_r.bank);
                        chk("dly_pend_T55", dly_pend, m_r.dly);
                        chk("locked_T55", locked, m_r.lck);
                        chk("addr_T55", addr, m_r.addr);
                    end
                    default: ;
                endcase
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst = 1'b0; sync = 1'b0; ia = 1'b0; is = 1'b0;
        model_reset();
        push_rst();
        repeat (3) @(posedge cph2);
        #1;
        nrst = 1'b1;

        word(1'b0, 8'h11, gen_inst(4, 3'd0), 1'b0);          // acquire lock
        word(1'b0, 8'hA5, 10'b101_0110000, 1'b0);            // addr A5, bank 5
        word(1'b0, 8'h5A, gen_inst(2, 3'd0), 1'b0);          // key jump, rom_en 20
        word(1'b0, 8'h0F, gen_inst(1, 3'd3), 1'b0);          // delayed -> 3
        word(1'b0, 8'hF0, gen_inst(4, 3'd0), 1'b0);          // non-branch
        word(1'b0, 8'h81, 10'b000_0000001, 1'b0);            // branch applies 3
        word(1'b0, 8'h42, gen_inst(1, 3'd6), 1'b0);          // delayed -> 6
        word(1'b0, 8'h24, gen_inst(2, 3'd0), 1'b0);          // key jump cancels
        word(1'b0, 8'hC3, gen_inst(0, 3'd4), 1'b0);          // immediate 4
        word(1'b1, 8'h3C, gen_inst(0, 3'd1), 1'b0);          // sync missing at T45
        word(1'b0, 8'h99, gen_inst(0, 3'd7), 1'b0);          // relock, no decode
        word(1'b0, 8'h66, gen_inst(1, 3'd2), 1'b0);          // delayed -> 2
        word(1'b0, 8'h77, gen_inst(3, 3'd0), 1'b1);          // reset at T50
        word(1'b0, 8'h12, gen_inst(0, 3'd5), 1'b0);          // reacquire
        word(1'b0, 8'h34, gen_inst(4, 3'd0), 1'b0);

        for (int w = 0; w < 40; w++) begin
            word($urandom_range(0, 9) == 0, 8'($urandom),
                 gen_inst(int'($urandom_range(0, 4)), 3'($urandom)),
                 $urandom_range(0, 29) == 0);
        end
        word(1'b0, 8'hE7, gen_inst(4, 3'd0), 1'b0);
        word(1'b0, 8'h7E, gen_inst(3, 3'd0), 1'b0);

        repeat (2) @(posedge cph2);
        #1;
        chk("addr_queue_drained", q_addr.size(), 0);
        chk("word_queue_drained", q_word.size(), 0);
        chk("sync_err_pulse_count", err_seen, err_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
